mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Two-requester arbiter and sequencer for the single shared RAM behind the cache level. It lets e.g. an instruction-side and a data-side cache share one RAM. Each requester issues one word read/write with a valid/done handshake. The block serialises accesses with round-robin fairness, holds RAM inputs stable for the whole access, and waits on the RAM's response line. A watchdog converts a hung RAM access into an error completion.

Parameters:
ADDR_W, 32, address width of requesters and RAM
DATA_W, 32, data word width
TIMEOUT, 64, max cycles spent in WAIT before forcing an error completion (≥2)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 access pending
req0_wr  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  access address
req0_data  in  DATA_W  write data
req0_done  out  1  one-cycle completion pulse
req0_rdata  out  DATA_W  read data, valid from done pulse until next read completion of port 0
req0_err  out  1  qualifies done: access timed out
req1_*  same set as req0_* for requester 1
ram_req  out  1  access strobe to RAM, high ISSUE through WAIT
ram_wr  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_data  out  DATA_W  RAM write data
ram_response  in  1  RAM finished current access
ram_out  in  DATA_W  RAM read data, valid with ram_response
busy  out  1  state != IDLE
last_grant  out  1  id of most recently completed requester

Behaviour:
- Reset (async, any state): state=IDLE.
  - ram_req, ram_wr, ram_addr, ram_data, reqN_done, reqN_err, reqN_rdata, busy = 0.
  - last_grant=1, so port 0 wins the first tie.
  - An in-flight RAM access is abandoned; ram_req drops immediately.
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Neither valid: stay.
  - One valid: grant it.
  - Both valid: grant the port ≠ last_grant.
  - On grant: latch wr/addr/data of the granted port into internal regs, record the grant id, go to ISSUE.
- ISSUE: ram_req=1 and ram_* driven from the latched regs. ram_response is ignored this cycle because it may be stale from the previous access. Clear the watchdog, go to WAIT.
- WAIT:
  - ram_req stays 1; ram_* stay stable and do not follow requester inputs.
  - Watchdog increments each cycle.
  - ram_response=1: capture ram_out if read, go to RESP with err=0.
  - Watchdog reaches TIMEOUT-1 with ram_response still 0: go to RESP with err=1.
  - ram_response wins if it coincides with the timeout cycle.
- RESP:
  - ram_req=0.
  - Granted port: done=1 and err as determined for exactly one cycle. rdata is updated on a successful read only; it is unchanged on a write or an error.
  - last_grant ← granted id; go to IDLE.
- Requester contract:
  - Hold valid and its fields stable until done.
  - Deassert valid or present a new request on the edge where done is seen.
  - Changes to a requester's inputs while it is waiting are not sampled.
- RAM contract: ram_response is low by the first WAIT cycle of a new access.
- Latency: valid sampled in IDLE at cycle T gives ISSUE T+1 and WAIT T+2. With ram_response=1 at T+2, done is high at T+3 (minimum 3 cycles). Back-to-back throughput is one access per 4 cycles.
- Fairness: with both valids held, grants strictly alternate. A lone requester may be granted repeatedly.
- Ungranted port: its done/err stay 0 the entire time.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - port-id constants PORT0=0, PORT1=1
  - default ADDR_W/DATA_W constants, also used by the cache blocks
- One sub-module: rr_arb2 (combinational two-way round-robin pick from valids + last_grant, outputs grant id and grant_valid).
- Watchdog counter and FSM stay in the top.

Test Plan:
- Single read: req0 read addr 0x10, RAM returns 0xDEADBEEF two cycles after ram_req rises → ram_addr=0x10, ram_wr=0, req0_done one cycle with rdata=0xDEADBEEF, err=0, last_grant=0.
- Contention: req0 write 0x20←0x1111 and req1 read 0x30 both valid at cycle T after reset → port 0 served first; port 1 issued in the next ISSUE. Grants alternate 0,1,0,1 over four held requests.
- Stability: change req0_addr to 0x99 during WAIT → ram_addr stays at the latched 0x20 until RESP.
- Timeout: ram_response held 0 → done with err=1 exactly TIMEOUT+1 cycles after ISSUE. rdata keeps its prior value, and the next request proceeds normally.
- Stale response: ram_response stuck 1 through ISSUE → not taken in ISSUE. It is accepted in the first WAIT cycle, giving minimum latency of 3.
- Reset mid-access: assert rst during WAIT → ram_req, busy and done drop asynchronously with no done pulse. After release, a pending req1 still loses a tie to req0 (last_grant=1).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM port arbiter and the cache blocks around it.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time goes.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       grant,
   output logic       grant_valid
);

   // Pure combinational pick; a lone requester always wins.
   always_comb begin
      grant       = PORT0;
      grant_valid = |valid;
      if (&valid)
         grant = ~last_grant;
      else if (valid[1])
         grant = PORT1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises word accesses from two requesters onto one RAM, round-robin,
// with a watchdog that turns a hung RAM access into an error completion.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req0_wr,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic              req1_wr,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_err,
   output logic              ram_req,
   output logic              ram_wr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   input  logic              ram_response,
   input  logic [DATA_W-1:0] ram_out,
   output logic              busy,
   output logic              last_grant
);

   localparam int WD_W = $clog2(TIMEOUT);

   state_t            state_q, state_d;
   logic              gnt_q, wr_q, err_q, last_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q, rdata0_q, rdata1_q;
   logic [WD_W-1:0]   wd_q;

   logic grant, grant_valid;
   logic latch, wd_clr, wd_inc, resp_ok, resp_to;

   rr_arb2 u_arb (
      .valid       ({req1_valid, req0_valid}),
      .last_grant  (last_q),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // State register; reset abandons any in-flight access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and datapath strobes. ram_response is not looked at in ISSUE
   // because it may still be high from the previous access.
   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      wd_clr  = 1'b0;
      wd_inc  = 1'b0;
      resp_ok = 1'b0;
      resp_to = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               latch   = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wd_clr  = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            wd_inc = 1'b1;
            if (ram_response) begin
               resp_ok = 1'b1;
               state_d = RESP;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               resp_to = 1'b1;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latched request, watchdog, completion status, read data and grant history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q    <= PORT0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
         wd_q     <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         last_q   <= PORT1;
      end else begin
         if (latch) begin
            gnt_q  <= grant;
            wr_q   <= grant ? req1_wr   : req0_wr;
            addr_q <= grant ? req1_addr : req0_addr;
            data_q <= grant ? req1_data : req0_data;
         end
         if (wd_clr)      wd_q <= '0;
         else if (wd_inc) wd_q <= wd_q + 1'b1;
         if (resp_ok || resp_to) err_q <= resp_to;
         if (resp_ok && !wr_q) begin
            if (gnt_q == PORT1) rdata1_q <= ram_out;
            else                rdata0_q <= ram_out;
         end
         if (state_q == RESP) last_q <= gnt_q;
      end
   end

   assign ram_req    = (state_q == ISSUE) || (state_q == WAIT);
   assign ram_wr     = ram_req && wr_q;
   assign ram_addr   = addr_q;
   assign ram_data   = data_q;
   assign busy       = (state_q != IDLE);
   assign last_grant = last_q;

   assign req0_done  = (state_q == RESP) && (gnt_q == PORT0);
   assign req1_done  = (state_q == RESP) && (gnt_q == PORT1);
   assign req0_err   = req0_done && err_q;
   assign req1_err   = req1_done && err_q;
   assign req0_rdata = rdata0_q;
   assign req1_rdata = rdata1_q;

endmodule
